// File: rtl/ghost_mover.sv
// Tile-based ghost movement engine: every STEP_FRAMES frame ticks it probes up to three
// neighbouring tiles through a maze req/ack port and steps toward the chase target.
module ghost_mover #(
    parameter logic [4:0] START_X     = 5'd13,
    parameter logic [4:0] START_Y     = 5'd11,
    parameter logic [5:0] STEP_FRAMES = 6'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       enable,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [4:0] xpos,
    output logic [4:0] ypos,
    output logic [1:0] direction,
    output logic       busy,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PROBE  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_MOVE   = 3'd4
    } state_t;

    // Probe order is up(0), left(3), down(2), right(1), i.e. dir = -idx mod 4.
    // The reverse direction is removed from that list; k selects among the remaining three.
    function automatic logic [1:0] cand_dir(input logic [1:0] rev, input logic [1:0] k);
        logic [1:0] pos;
        logic [1:0] idx;
        pos = 2'd0 - rev;
        idx = (k < pos) ? k : k + 2'd1;
        return 2'd0 - idx;
    endfunction

    function automatic logic [9:0] step_tile(input logic [4:0] x, input logic [4:0] y,
                                             input logic [1:0] dir);
        logic [9:0] t;
        case (dir)
            2'd0:    t = {x, y - 5'd1};
            2'd1:    t = {x + 5'd1, y};
            2'd2:    t = {x, y + 5'd1};
            default: t = {x - 5'd1, y};
        endcase
        return t;
    endfunction

    function automatic logic [4:0] abs_diff(input logic [4:0] a, input logic [4:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    state_t     r_state;
    logic [5:0] r_cnt;
    logic [1:0] r_probe;
    logic [4:0] r_tx;
    logic [4:0] r_ty;
    logic       r_best_valid;
    logic [1:0] r_best_dir;
    logic [5:0] r_best_dist;
    logic [1:0] r_chosen;
    logic [4:0] r_x;
    logic [4:0] r_y;
    logic [1:0] r_dir;
    logic       r_wall_req;
    logic [4:0] r_wall_x;
    logic [4:0] r_wall_y;
    logic       r_overrun;

    logic       w_tick;
    logic [1:0] w_rev;
    logic [1:0] w_cdir;
    logic [9:0] w_ctile;
    logic [9:0] w_mtile;
    logic [5:0] w_dist;

    assign w_tick  = ce && (r_cnt == STEP_FRAMES - 6'd1);
    assign w_rev   = r_dir ^ 2'd2;
    assign w_cdir  = cand_dir(w_rev, r_probe);
    assign w_ctile = step_tile(r_x, r_y, w_cdir);
    assign w_mtile = step_tile(r_x, r_y, r_chosen);
    assign w_dist  = {1'b0, abs_diff(r_wall_x, r_tx)} + {1'b0, abs_diff(r_wall_y, r_ty)};

    // Maze port handshake: wall_req rises with wall_x/wall_y and both stay frozen until a
    // cycle where wall_ack=1; wall_hit is sampled in that same cycle and wall_req drops next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            r_probe      <= 2'd0;
            r_tx         <= 5'd0;
            r_ty         <= 5'd0;
            r_best_valid <= 1'b0;
            r_best_dir   <= 2'd0;
            r_best_dist  <= 6'd0;
            r_chosen     <= 2'd0;
            r_x          <= START_X;
            r_y          <= START_Y;
            r_dir        <= 2'd3;
            r_wall_req   <= 1'b0;
            r_wall_x     <= 5'd0;
            r_wall_y     <= 5'd0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_tick && (r_state != S_IDLE);
            if (ce) begin
                r_cnt <= w_tick ? 6'd0 : r_cnt + 6'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick && enable) begin
                        r_tx         <= target_x;
                        r_ty         <= target_y;
                        r_probe      <= 2'd0;
                        r_best_valid <= 1'b0;
                        r_state      <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    r_wall_x   <= w_ctile[9:5];
                    r_wall_y   <= w_ctile[4:0];
                    r_wall_req <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wall_ack) begin
                        r_wall_req <= 1'b0;
                        // Strict less-than keeps the earlier probe on a tie.
                        if (!wall_hit && (!r_best_valid || w_dist < r_best_dist)) begin
                            r_best_valid <= 1'b1;
                            r_best_dir   <= w_cdir;
                            r_best_dist  <= w_dist;
                        end
                        if (r_probe == 2'd2) begin
                            r_state <= S_DECIDE;
                        end else begin
                            r_probe <= r_probe + 2'd1;
                            r_state <= S_PROBE;
                        end
                    end
                end
                S_DECIDE: begin
                    r_chosen <= r_best_valid ? r_best_dir : w_rev;
                    r_state  <= S_MOVE;
                end
                S_MOVE: begin
                    r_dir   <= r_chosen;
                    r_x     <= w_mtile[9:5];
                    r_y     <= w_mtile[4:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wall_req  = r_wall_req;
    assign wall_x    = r_wall_x;
    assign wall_y    = r_wall_y;
    assign xpos      = r_x;
    assign ypos      = r_y;
    assign direction = r_dir;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: a maze model answers probes, expected moves are queued
// by the stimulus and a negedge monitor checks each completed move against the queue.
module tb_ghost_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       enable = 1'b1;
    logic [4:0] target_x = 5'd0;
    logic [4:0] target_y = 5'd11;
    logic       wall_req;
    logic [4:0] wall_x;
    logic [4:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;
    logic [4:0] xpos;
    logic [4:0] ypos;
    logic [1:0] direction;
    logic       busy;
    logic       overrun;
    logic [2:0] dbg_state;

    logic        ack_en = 1'b1;
    logic [31:0] maze [32];
    logic [11:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          ovr_cnt = 0;

    always #5 clk = ~clk;

    ghost_mover dut (
        .clk(clk), .reset(reset), .ce(ce), .enable(enable),
        .target_x(target_x), .target_y(target_y),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .xpos(xpos), .ypos(ypos), .direction(direction),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    assign wall_ack = wall_req & ack_en;
    assign wall_hit = maze[wall_y][wall_x];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a busy falling edge not caused by reset is a completed move.
    initial begin
        logic       prev_busy = 1'b0;
        logic       prev_rst = 1'b1;
        logic       prev_req = 1'b0;
        logic       prev_ack = 1'b0;
        logic [4:0] prev_wx = 5'd0;
        logic [4:0] prev_wy = 5'd0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (prev_busy && !busy && !prev_rst) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_move actual=(%0d,%0d,%0d) required=none",
                             xpos, ypos, direction);
                end else begin
                    e = exp_q.pop_front();
                    check("move_xyd", {20'd0, xpos, ypos, direction}, {20'd0, e});
                end
            end
            if (wall_req && prev_req && !prev_ack && !prev_rst)
                check("probe_hold", {22'd0, wall_x, wall_y}, {22'd0, prev_wx, prev_wy});
            prev_busy = busy;
            prev_rst  = reset;
            prev_req  = wall_req;
            prev_ack  = wall_ack;
            prev_wx   = wall_x;
            prev_wy   = wall_y;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_maze();
        for (int i = 0; i < 32; i++) maze[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ce     = 1'b0;
        ack_en = 1'b1;
        enable = 1'b1;
        clear_maze();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic ce_pulses(input int n);
        ce = 1'b1;
        repeat (n) @(posedge clk);
        #1 ce = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL move_timeout actual=pending%0d required=pending0", exp_q.size());
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
        exp_q.push_back({x, y, d});
        ce_pulses(8);
        wait_done();
    endtask

    task automatic check_idle_at(input string name, input logic [4:0] x, input logic [4:0] y,
                                 input logic [1:0] d);
        @(negedge clk);
        check({name, "_pos"}, {20'd0, xpos, ypos, direction}, {20'd0, x, y, d});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_req"}, {31'd0, wall_req}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        clear_maze();
        @(posedge clk);
        #1;

        // Reset values.
        do_reset();
        @(negedge clk);
        check("rst_xpos", {27'd0, xpos}, 32'd13);
        check("rst_ypos", {27'd0, ypos}, 32'd11);
        check("rst_dir", {30'd0, direction}, 32'd3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, wall_req}, 32'd0);
        check("rst_wall_xy", {22'd0, wall_x, wall_y}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;

        // A tick with enable low is discarded without overrun.
        base = ovr_cnt;
        enable = 1'b0;
        ce_pulses(8);
        repeat (10) @(posedge clk);
        #1 enable = 1'b1;
        check_idle_at("disabled", 5'd13, 5'd11, 2'd3);
        check("disabled_ovr", ovr_cnt - base, 32'd0);

        // Walk left to x=0 toward (0,11), then wrap to 31 with only left open.
        base = ovr_cnt;
        target_x = 5'd0;
        target_y = 5'd11;
        for (int k = 12; k >= 0; k--) step(5'(k), 5'd11, 2'd3);
        maze[10][0] = 1'b1;
        maze[12][0] = 1'b1;
        target_x = 5'd31;
        step(5'd31, 5'd11, 2'd3);
        check("walk_ovr", ovr_cnt - base, 32'd0);

        // Counter cleared by reset; all three probes walled -> reverse.
        ce_pulses(3);
        do_reset();
        maze[10][13] = 1'b1;
        maze[11][12] = 1'b1;
        maze[12][13] = 1'b1;
        target_x = 5'd0;
        target_y = 5'd11;
        exp_q.push_back({5'd14, 5'd11, 2'd1});
        ce_pulses(7);
        @(negedge clk);
        check("no_tick_at_7", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        ce_pulses(1);
        wait_done();

        // From (14,11) heading right, target (14,5): up dist 5 beats down/right dist 7.
        clear_maze();
        target_x = 5'd14;
        target_y = 5'd5;
        step(5'd14, 5'd10, 2'd0);

        // Long ack stall with one dropped tick during the wait.
        do_reset();
        target_x = 5'd0;
        target_y = 5'd11;
        ack_en = 1'b0;
        base = ovr_cnt;
        exp_q.push_back({5'd12, 5'd11, 2'd3});
        ce_pulses(8);
        ce_pulses(8);
        @(negedge clk);
        check("stall_req", {31'd0, wall_req}, 32'd1);
        check("stall_wall_xy", {22'd0, wall_x, wall_y}, {22'd0, 5'd13, 5'd10});
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1 ack_en = 1'b1;
        wait_done();
        check("stall_ovr", ovr_cnt - base, 32'd1);
        check_idle_at("stall_end", 5'd12, 5'd11, 2'd3);

        // Reset while a probe is outstanding aborts the decision.
        do_reset();
        target_x = 5'd0;
        target_y = 5'd11;
        ack_en = 1'b0;
        ce_pulses(8);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = wall_req;
            end
            check("abort_req_seen", {31'd0, seen}, 32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        ack_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_req", {31'd0, wall_req}, 32'd0);
        check("abort_pos", {20'd0, xpos, ypos, direction}, {20'd0, 5'd13, 5'd11, 2'd3});
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        #1;
        check_idle_at("abort_after", 5'd13, 5'd11, 2'd3);
        check("abort_queue", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
GHOST_MOVER -- requirements
Module: ghost_mover

Interface
REQ-001 SHALL have parameter START_X, default 5'd13, meaning reset tile column.
REQ-002 SHALL have parameter START_Y, default 5'd11, meaning reset tile row.
REQ-003 SHALL have parameter STEP_FRAMES, default 6'd8, meaning ce pulses per tile step (1..63).
REQ-004 SHALL have port clk, input, 1, the system clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port ce, input, 1, one-cycle frame-tick pulse.
REQ-007 SHALL have port enable, input, 1, movement enable; 0 freezes stepping.
REQ-008 SHALL have port target_x / target_y, input, 5 each, chase target tile.
REQ-009 SHALL have port wall_req, output, 1, maze-probe request.
REQ-010 SHALL have port wall_x / wall_y, output, 5 each, tile being probed.
REQ-011 SHALL have port wall_ack, input, 1, probe accepted; wall_hit valid in the same cycle.
REQ-012 SHALL have port wall_hit, input, 1, 1 = probed tile is a wall.
REQ-013 SHALL have port xpos / ypos, output, 5 each, current ghost tile, registered.
REQ-014 SHALL have port direction, output, 2, 0=up 1=right 2=down 3=left, registered.
REQ-015 SHALL have port busy, output, 1, high whenever FSM is not IDLE.
REQ-016 SHALL have port overrun, output, 1, one-cycle pulse when a step tick is dropped.

Function
REQ-017 SHALL keep a 6-bit frame counter: +1 per ce; on ce with counter==STEP_FRAMES-1, it clears and raises a step tick.
REQ-018 SHALL start a decision only on a step tick with enable=1 in IDLE; a tick outside IDLE SHALL be dropped with overrun=1 for that cycle; a tick with enable=0 SHALL be silently discarded.
REQ-019 SHALL implement FSM IDLE -> PROBE -> WAIT -> (PROBE | DECIDE) -> MOVE -> IDLE.
REQ-020 SHALL probe candidates in order up, left, down, right, skipping the reverse of current direction (direction^2): three probes per decision.
REQ-021 SHALL compute candidate tile mod 32 (up: y-1, down: y+1, left: x-1, right: x+1; 0-1 wraps to 31, 31+1 wraps to 0).
REQ-022 PROBE SHALL assert wall_req with wall_x/wall_y; WAIT SHALL hold them stable until a cycle with wall_ack=1, then drop wall_req the next cycle; a wait of any length SHALL be tolerated.
REQ-023 SHALL compute for each non-wall candidate the unsigned distance |cx-target_x|+|cy-target_y| (6 bits, no wrap); a candidate SHALL replace the current best only if strictly smaller, so ties favour probe order.
REQ-024 DECIDE SHALL select the best open candidate; if all three are walls, it SHALL select the reverse direction without probing it.
REQ-025 MOVE SHALL update direction and xpos/ypos to the chosen tile in one cycle, then return to IDLE; latency from tick to position update = 3 probes x (1 + ack wait) + 2 cycles.
REQ-026 target_x/target_y SHALL be sampled once at decision start and held for that decision.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 On reset SHALL set xpos=START_X, ypos=START_Y, direction=3, counter=0, FSM=IDLE, wall_req=0, wall_x=wall_y=0, busy=0, overrun=0.
REQ-029 Reset asserted mid-decision (including WAIT with wall_req=1) SHALL abort it in the next cycle with no position update; a pending wall_ack SHALL be ignored.

Verification
REQ-030 Reset, STEP_FRAMES=8, 8 ce pulses, ack same cycle, no walls, target (0,11) -> left chosen, xpos 13->12, direction=3.
REQ-031 At (13,11) dir=3, walls at up/left/down -> reverse taken: direction=1, xpos=14.
REQ-032 At x=0, dir=3, target (31,11), only left open -> xpos wraps to 31.
REQ-033 Target (13,5) from (13,11) dir=1, up and left tie-free: up (dist 5) beats right (dist 7) -> ypos=10, direction=0.
REQ-034 wall_ack withheld 20 cycles during first probe -> wall_x/wall_y stable throughout; a step tick during that wait pulses overrun=1 once; position updates once.
REQ-035 reset asserted while wall_req=1 -> next cycle wall_req=0, xpos=13, ypos=11, direction=3, busy=0.
